vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 143 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 Hz VGA timing generator with vertical-blank update handshake
//
// Purpose:
//   Divides the system clock into a pixel tick and runs the horizontal and
//   vertical pixel counters. The sync, video-enable and strobe outputs are
//   registered so that they line up with hcnt/vcnt in the same cycle.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   clr          in   synchronous active-high reset
//   upd_req      in   level, producer has new display values pending
//   hcnt         out  pixel column, 0..H_TOTAL-1
//   vcnt         out  line, 0..V_TOTAL-1
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   vidon        out  high inside the visible window
//   pix_tick     out  one-clk pulse in the first cycle of each new pixel
//   line_start   out  one-clk pulse when hcnt becomes 0
//   frame_start  out  one-clk pulse when (hcnt,vcnt) becomes (0,0)
//   upd_ack      out  one-clk pulse granting the update at (0,V_VIS_END)

module vga_sync_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_VIS        = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_TOTAL      = 521,
  parameter int V_SYNC_END   = 2,
  parameter int V_VIS_START  = 31,
  parameter int V_VIS_END    = 511
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       upd_req,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic       upd_ack
);

  // A divide-by-one build still needs a one-bit divider register; it simply
  // stays at zero so that every edge is an advance.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
  localparam logic [9:0] H_SS_C     = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE_C     = 10'(H_SYNC_END);
  localparam logic [9:0] V_SE_C     = 10'(V_SYNC_END);
  localparam logic [9:0] V_VS_C     = 10'(V_VIS_START);
  localparam logic [9:0] V_VE_C     = 10'(V_VIS_END);

  logic [DIV_W-1:0] div;
  logic             advance;

  logic [9:0] hcnt_nx;
  logic [9:0] vcnt_nx;
  logic       hsync_nx;
  logic       vsync_nx;
  logic       vidon_nx;
  logic       line_nx;
  logic       frame_nx;
  logic       ack_nx;

  assign advance = (div == DIV_LAST);

  // Next counter position and everything decoded from it. The decodes are
  // taken from the next position so the registered outputs match the
  // registered counters with no pipeline skew.
  always_comb begin
    hcnt_nx = hcnt + 10'd1;
    vcnt_nx = vcnt;
    if (hcnt == H_LAST) begin
      hcnt_nx = 10'd0;
      if (vcnt == V_LAST) begin
        vcnt_nx = 10'd0;
      end else begin
        vcnt_nx = vcnt + 10'd1;
      end
    end

    hsync_nx = !((hcnt_nx >= H_SS_C) && (hcnt_nx < H_SE_C));
    vsync_nx = !(vcnt_nx < V_SE_C);
    vidon_nx = (hcnt_nx < H_VIS_C) && (vcnt_nx >= V_VS_C) && (vcnt_nx < V_VE_C);

    line_nx  = (hcnt_nx == 10'd0);
    frame_nx = line_nx && (vcnt_nx == 10'd0);
    // upd_req is looked at only on the single advance into the first
    // blanking line; a later request waits a whole frame.
    ack_nx   = line_nx && (vcnt_nx == V_VE_C) && upd_req;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div <= '0;
    end else if (advance) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Counters and level decodes hold between advances.
  always_ff @(posedge clk) begin
    if (clr) begin
      hcnt  <= 10'd0;
      vcnt  <= 10'd0;
      hsync <= 1'b1;
      vsync <= 1'b0;
      vidon <= 1'b0;
    end else if (advance) begin
      hcnt  <= hcnt_nx;
      vcnt  <= vcnt_nx;
      hsync <= hsync_nx;
      vsync <= vsync_nx;
      vidon <= vidon_nx;
    end
  end

  // Strobes are rewritten on every edge so each lasts exactly one clk.
  always_ff @(posedge clk) begin
    if (clr) begin
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      upd_ack     <= 1'b0;
    end else begin
      pix_tick    <= advance;
      line_start  <= advance && line_nx;
      frame_start <= advance && frame_nx;
      upd_ack     <= advance && ack_nx;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen

module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Full-size geometry, divide by 4
  logic       clr4 = 1'b1;
  logic       req4 = 1'b0;
  logic [9:0] h4, v4;
  logic       hs4, vs4, vo4, pt4, ls4, fs4, ua4;

  // Reduced geometry, divide by 2, so whole frames fit in a short run:
  // 20 x 16 pixels, visible 12 columns x lines 4..12, vsync lines 0..1
  logic       clr_s = 1'b1;
  logic       req_s = 1'b0;
  logic [9:0] h_s, v_s;
  logic       hs_s, vs_s, vo_s, pt_s, ls_s, fs_s, ua_s;

  // Full-size geometry, divide by 1
  logic       clr1 = 1'b1;
  logic       req1 = 1'b0;
  logic [9:0] h1, v1;
  logic       hs1, vs1, vo1, pt1, ls1, fs1, ua1;

  vga_sync_gen #(.CLK_DIV(4)) dut4 (
    .clk(clk), .clr(clr4), .upd_req(req4), .hcnt(h4), .vcnt(v4),
    .hsync(hs4), .vsync(vs4), .vidon(vo4), .pix_tick(pt4),
    .line_start(ls4), .frame_start(fs4), .upd_ack(ua4)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_VIS(12), .H_SYNC_START(14), .H_SYNC_END(17),
    .V_TOTAL(16), .V_SYNC_END(2), .V_VIS_START(4), .V_VIS_END(13)
  ) dut_s (
    .clk(clk), .clr(clr_s), .upd_req(req_s), .hcnt(h_s), .vcnt(v_s),
    .hsync(hs_s), .vsync(vs_s), .vidon(vo_s), .pix_tick(pt_s),
    .line_start(ls_s), .frame_start(fs_s), .upd_ack(ua_s)
  );

  vga_sync_gen #(.CLK_DIV(1)) dut1 (
    .clk(clk), .clr(clr1), .upd_req(req1), .hcnt(h1), .vcnt(v1),
    .hsync(hs1), .vsync(vs1), .vidon(vo1), .pix_tick(pt1),
    .line_start(ls1), .frame_start(fs1), .upd_ack(ua1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({h4, v4} !== 20'd0 || hs4 !== 1'b1 || vs4 !== 1'b0 || vo4 !== 1'b0 ||
          pt4 !== 1'b0 || ls4 !== 1'b0 || fs4 !== 1'b0 || ua4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_values clk=%0d got h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b ls=%b fs=%b ua=%b want 0 0 1 0 0 0 0 0 0",
                 i, h4, v4, hs4, vs4, vo4, pt4, ls4, fs4, ua4);
      end
    end
    clr4 = 1'b0;
    // Edge k after release: hcnt = k/4, pix_tick only on multiples of 4
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (h4 !== 10'(k / 4) || pt4 !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL first_advance edge=%0d got h=%0d pt=%b want h=%0d pt=%b",
                 k, h4, pt4, k / 4, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_hdecode();
    int low_clks = 0;
    int mism = 0;
    int ls_cnt = 0;
    int vo_cnt = 0;
    logic [9:0] prev_h;
    logic done = 1'b0;
    prev_h = h4;
    for (int c = 0; c < 4000 && !done; c++) begin
      tick();
      if (hs4 === 1'b0) low_clks++;
      if (hs4 !== !(h4 >= 10'd656 && h4 < 10'd752)) mism++;
      if (ls4 === 1'b1) ls_cnt++;
      if (vo4 === 1'b1) vo_cnt++;
      if (prev_h == 10'd799 && h4 == 10'd0) done = 1'b1;
      prev_h = h4;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL hwrap_timeout got no 799->0 wrap want wrap within 4000 clks");
    end
    checks++;
    if (v4 !== 10'd1 || ls4 !== 1'b1) begin
      errors++;
      $display("FAIL hwrap_state got v=%0d ls=%b want v=1 ls=1", v4, ls4);
    end
    checks++;
    if (ls_cnt != 1) begin
      errors++;
      $display("FAIL line_start_count got %0d want 1", ls_cnt);
    end
    checks++;
    if (low_clks != 384 || mism != 0) begin
      errors++;
      $display("FAIL hsync_low got clks=%0d mism=%0d want clks=384 mism=0", low_clks, mism);
    end
    checks++;
    if (vo_cnt != 0) begin
      errors++;
      $display("FAIL vidon_line0 got %0d clks high want 0", vo_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int fs_cnt = 0;
    logic found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      if (h4 == 10'd400 && pt4 === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_reach got h=%0d want 400 with pix_tick", h4);
    end
    clr4 = 1'b1;
    tick();
    checks++;
    if ({h4, v4} !== 20'd0 || hs4 !== 1'b1 || vs4 !== 1'b0 || vo4 !== 1'b0 ||
        pt4 !== 1'b0 || ls4 !== 1'b0 || fs4 !== 1'b0 || ua4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values got h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b ls=%b fs=%b ua=%b want 0 0 1 0 0 0 0 0 0",
               h4, v4, hs4, vs4, vo4, pt4, ls4, fs4, ua4);
    end
    clr4 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (fs4 === 1'b1) fs_cnt++;
    end
    checks++;
    if (h4 !== 10'd2 || v4 !== 10'd0 || fs_cnt != 0) begin
      errors++;
      $display("FAIL midreset_restart got h=%0d v=%0d fs=%0d want h=2 v=0 fs=0", h4, v4, fs_cnt);
    end
  endtask

  task automatic test_vdecode();
    int cyc = 0, nfs = 0, first = 0, second = 0;
    int vs_low = 0, vs_mism = 0, vo_cnt = 0, vo_bad = 0, ls_cnt = 0, pt_cnt = 0;
    int fs_pos_bad = 0;
    logic vo_a = 1'b0, vo_b = 1'b0, vo_c = 1'b1;
    clr_s = 1'b0;
    for (int c = 0; c < 2000 && nfs < 2; c++) begin
      tick();
      cyc++;
      if (fs_s === 1'b1) begin
        nfs++;
        if (h_s != 10'd0 || v_s != 10'd0) fs_pos_bad++;
        if (nfs == 1) first = cyc;
        if (nfs == 2) second = cyc;
      end
      if (nfs == 1) begin
        if (vs_s === 1'b0) vs_low++;
        if (vs_s !== (v_s >= 10'd2)) vs_mism++;
        if (vo_s === 1'b1) vo_cnt++;
        if (vo_s === 1'b1 && (v_s == 10'd3 || v_s == 10'd13)) vo_bad++;
        if (h_s == 10'd0 && v_s == 10'd4) vo_a = vo_s;
        if (h_s == 10'd11 && v_s == 10'd12) vo_b = vo_s;
        if (h_s == 10'd12 && v_s == 10'd4) vo_c = vo_s;
        if (ls_s === 1'b1) ls_cnt++;
        if (pt_s === 1'b1) pt_cnt++;
      end
    end
    checks++;
    if (first != 640 || second != 1280 || fs_pos_bad != 0) begin
      errors++;
      $display("FAIL frame_period got first=%0d second=%0d badpos=%0d want 640 1280 0",
               first, second, fs_pos_bad);
    end
    checks++;
    if (vs_low != 80 || vs_mism != 0) begin
      errors++;
      $display("FAIL vsync_low got clks=%0d mism=%0d want 80 0", vs_low, vs_mism);
    end
    checks++;
    if (vo_cnt != 216 || vo_bad != 0) begin
      errors++;
      $display("FAIL vidon_window got clks=%0d bad=%0d want 216 0", vo_cnt, vo_bad);
    end
    checks++;
    if (vo_a !== 1'b1 || vo_b !== 1'b1 || vo_c !== 1'b0) begin
      errors++;
      $display("FAIL vidon_corners got %b%b%b want 110", vo_a, vo_b, vo_c);
    end
    checks++;
    if (ls_cnt != 16 || pt_cnt != 320) begin
      errors++;
      $display("FAIL strobe_counts got ls=%0d pt=%0d want 16 320", ls_cnt, pt_cnt);
    end
  endtask

  // Request raised at the top of line 7: grant 120 pixels (240 clks) later at (0,13)
  task automatic test_upd_early();
    int cyc = 0;
    logic got = 1'b0;
    for (int c = 0; c < 700 && !(v_s == 10'd7 && pt_s === 1'b1); c++) tick();
    req_s = 1'b1;
    for (int c = 0; c < 700 && !got; c++) begin
      tick();
      cyc++;
      if (ua_s === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || cyc != 240 || h_s !== 10'd0 || v_s !== 10'd13) begin
      errors++;
      $display("FAIL upd_early got ack=%b after=%0d at (%0d,%0d) want ack after 240 at (0,13)",
               got, cyc, h_s, v_s);
    end
    req_s = 1'b0;
    tick();
    checks++;
    if (ua_s !== 1'b0) begin
      errors++;
      $display("FAIL upd_ack_width got %b want 0 one clk after ack", ua_s);
    end
  endtask

  // Request raised at (5,13) misses this frame: grant 315 pixels (630 clks) later
  task automatic test_upd_late();
    int cyc = 0;
    logic got = 1'b0;
    for (int c = 0; c < 700 && !(h_s == 10'd5 && v_s == 10'd13 && pt_s === 1'b1); c++) tick();
    req_s = 1'b1;
    for (int c = 0; c < 1000 && !got; c++) begin
      tick();
      cyc++;
      if (ua_s === 1'b1) got = 1'b1;
    end
    req_s = 1'b0;
    checks++;
    if (!got || cyc != 630 || h_s !== 10'd0 || v_s !== 10'd13) begin
      errors++;
      $display("FAIL upd_late got ack=%b after=%0d at (%0d,%0d) want ack after 630 at (0,13)",
               got, cyc, h_s, v_s);
    end
  endtask

  task automatic test_upd_none();
    int acks = 0;
    req_s = 1'b0;
    for (int c = 0; c < 700; c++) begin
      tick();
      if (ua_s === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL upd_none got %0d acks want 0", acks);
    end
  endtask

  task automatic test_div1();
    int not_pt = 0, ls_a = 0, ls_b = 0;
    clr1 = 1'b0;
    tick();
    checks++;
    if (h1 !== 10'd1 || pt1 !== 1'b1) begin
      errors++;
      $display("FAIL div1_first got h=%0d pt=%b want h=1 pt=1", h1, pt1);
    end
    for (int k = 2; k <= 1700; k++) begin
      tick();
      if (pt1 !== 1'b1) not_pt++;
      if (ls1 === 1'b1) begin
        if (ls_a == 0) ls_a = k;
        else if (ls_b == 0) ls_b = k;
      end
    end
    checks++;
    if (not_pt != 0) begin
      errors++;
      $display("FAIL div1_pix_tick got %0d low clks want 0", not_pt);
    end
    checks++;
    if (ls_a != 800 || ls_b != 1600) begin
      errors++;
      $display("FAIL div1_line got starts at %0d %0d want 800 1600", ls_a, ls_b);
    end
  endtask

  initial begin
    test_reset();
    test_hdecode();
    test_mid_reset();
    test_vdecode();
    test_upd_early();
    test_upd_late();
    test_upd_none();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
